// File: rtl/sha256_compress_iter_if.sv
// Handshake bundle for the iterative SHA-256 compression engine.
// The master side offers a block plus chaining state and consumes the digest;
// the slave side is the engine.
interface sha256_compress_iter_if;
    logic         in_valid;
    logic         in_ready;
    logic [511:0] block_in;
    logic [255:0] state_in;
    logic         out_valid;
    logic         out_ready;
    logic [255:0] digest_out;
    logic         busy;

    modport master (
        output in_valid, block_in, state_in, out_ready,
        input  in_ready, out_valid, digest_out, busy
    );

    modport slave (
        input  in_valid, block_in, state_in, out_ready,
        output in_ready, out_valid, digest_out, busy
    );
endinterface

// File: rtl/sha256_compress_iter.sv
// Iterative SHA-256 compression engine.
// Runs UNROLL rounds per clock, expanding the message schedule in a 16-word
// sliding window. Optional feed-forward (chaining state added to the final
// working variables) is enabled by defining SHA256_FEEDFWD_EN; without it the
// raw final working variables are emitted and the add happens downstream.
module sha256_compress_iter #(
    parameter int UNROLL = 1,
    parameter int CNT_W  = 7
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sha256_compress_iter_if.slave bus
);

    // Only power-of-two divisors of 64 up to 16 keep the window arithmetic simple.
    generate
        if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8 || UNROLL == 16)) begin : g_bad_unroll
            $error("sha256_compress_iter: UNROLL must be 1, 2, 4, 8 or 16");
        end
        if (CNT_W < 7) begin : g_bad_cnt_w
            $error("sha256_compress_iter: CNT_W must be at least 7 to hold 64");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fsm_e;

    localparam logic [CNT_W-1:0] CNT_STEP = CNT_W'(UNROLL);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(64 - UNROLL);

    // ------------------------------------------------------------------
    // SHA-256 helper functions
    // ------------------------------------------------------------------
    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 5'd3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 5'd10);
    endfunction

    function automatic logic [31:0] ch_fn(input logic [31:0] e, input logic [31:0] f,
                                          input logic [31:0] g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [31:0] maj_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    // One compression round on packed {a,b,c,d,e,f,g,h}.
    function automatic logic [255:0] sha_round(input logic [255:0] s, input logic [31:0] k,
                                               input logic [31:0] w);
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        {a, b, c, d, e, f, g, h} = s;
        t1 = h + big_sigma1(e) + ch_fn(e, f, g) + k + w;
        t2 = big_sigma0(a) + maj_fn(a, b, c);
        return {t1 + t2, a, b, c, d + t1, e, f, g};
    endfunction

`ifdef SHA256_FEEDFWD_EN
    // Word-wise modulo-2^32 add with no carry between words.
    function automatic logic [255:0] add_words(input logic [255:0] x, input logic [255:0] y);
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
        end
        return r;
    endfunction
`endif

    // Round constant ROM.
    function automatic logic [31:0] k_rom(input logic [5:0] t);
        logic [31:0] k;
        case (t)
            6'd0:  k = 32'h428a2f98;  6'd1:  k = 32'h71374491;
            6'd2:  k = 32'hb5c0fbcf;  6'd3:  k = 32'he9b5dba5;
            6'd4:  k = 32'h3956c25b;  6'd5:  k = 32'h59f111f1;
            6'd6:  k = 32'h923f82a4;  6'd7:  k = 32'hab1c5ed5;
            6'd8:  k = 32'hd807aa98;  6'd9:  k = 32'h12835b01;
            6'd10: k = 32'h243185be;  6'd11: k = 32'h550c7dc3;
            6'd12: k = 32'h72be5d74;  6'd13: k = 32'h80deb1fe;
            6'd14: k = 32'h9bdc06a7;  6'd15: k = 32'hc19bf174;
            6'd16: k = 32'he49b69c1;  6'd17: k = 32'hefbe4786;
            6'd18: k = 32'h0fc19dc6;  6'd19: k = 32'h240ca1cc;
            6'd20: k = 32'h2de92c6f;  6'd21: k = 32'h4a7484aa;
            6'd22: k = 32'h5cb0a9dc;  6'd23: k = 32'h76f988da;
            6'd24: k = 32'h983e5152;  6'd25: k = 32'ha831c66d;
            6'd26: k = 32'hb00327c8;  6'd27: k = 32'hbf597fc7;
            6'd28: k = 32'hc6e00bf3;  6'd29: k = 32'hd5a79147;
            6'd30: k = 32'h06ca6351;  6'd31: k = 32'h14292967;
            6'd32: k = 32'h27b70a85;  6'd33: k = 32'h2e1b2138;
            6'd34: k = 32'h4d2c6dfc;  6'd35: k = 32'h53380d13;
            6'd36: k = 32'h650a7354;  6'd37: k = 32'h766a0abb;
            6'd38: k = 32'h81c2c92e;  6'd39: k = 32'h92722c85;
            6'd40: k = 32'ha2bfe8a1;  6'd41: k = 32'ha81a664b;
            6'd42: k = 32'hc24b8b70;  6'd43: k = 32'hc76c51a3;
            6'd44: k = 32'hd192e819;  6'd45: k = 32'hd6990624;
            6'd46: k = 32'hf40e3585;  6'd47: k = 32'h106aa070;
            6'd48: k = 32'h19a4c116;  6'd49: k = 32'h1e376c08;
            6'd50: k = 32'h2748774c;  6'd51: k = 32'h34b0bcb5;
            6'd52: k = 32'h391c0cb3;  6'd53: k = 32'h4ed8aa4a;
            6'd54: k = 32'h5b9cca4f;  6'd55: k = 32'h682e6ff3;
            6'd56: k = 32'h748f82ee;  6'd57: k = 32'h78a5636f;
            6'd58: k = 32'h84c87814;  6'd59: k = 32'h8cc70208;
            6'd60: k = 32'h90befffa;  6'd61: k = 32'ha4506ceb;
            6'd62: k = 32'hbef9a3f7;  6'd63: k = 32'hc67178f2;
            default: k = 32'h00000000;
        endcase
        return k;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    fsm_e             fsm_q, fsm_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [255:0]     wv_q, wv_d;
    logic [31:0]      win_q [0:15];
    logic [31:0]      win_d [0:15];
    logic [255:0]     digest_q, digest_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
`ifdef SHA256_FEEDFWD_EN
    logic [255:0]     chain_q, chain_d;
`endif

    // Window extended by the UNROLL schedule words produced this cycle, and
    // the working-variable chain through the UNROLL rounds.
    logic [31:0]      ext_s [0:15+UNROLL];
    logic [255:0]     rs_s  [0:UNROLL];

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.busy       = busy_q;
    assign bus.digest_out = digest_q;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q <= ST_IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    // FSM next-state: accept in IDLE, finish after the last round group, drain on out_ready.
    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            ST_IDLE: begin
                if (bus.in_valid) fsm_d = ST_RUN;
                else              fsm_d = ST_IDLE;
            end
            ST_RUN: begin
                if (cnt_q == LAST_CNT) fsm_d = ST_DONE;
                else                   fsm_d = ST_RUN;
            end
            ST_DONE: begin
                if (bus.out_ready) fsm_d = ST_IDLE;
                else               fsm_d = ST_DONE;
            end
            default: fsm_d = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from the next state so they are registered with it.
    always_comb begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        case (fsm_d)
            ST_IDLE: in_ready_d  = 1'b1;
            ST_RUN:  busy_d      = 1'b1;
            ST_DONE: begin
                out_valid_d = 1'b1;
                busy_d      = 1'b1;
            end
            default: in_ready_d = 1'b1;
        endcase
    end

    // Handshake output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Schedule expansion and UNROLL chained rounds for the current group.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            ext_s[i] = win_q[i];
        end
        for (int j = 0; j < UNROLL; j++) begin
            ext_s[16+j] = small_sigma1(ext_s[14+j]) + ext_s[9+j]
                        + small_sigma0(ext_s[1+j]) + ext_s[j];
        end
        rs_s[0] = wv_q;
        for (int i = 0; i < UNROLL; i++) begin
            rs_s[i+1] = sha_round(rs_s[i], k_rom(cnt_q[5:0] + 6'(i)), ext_s[i]);
        end
    end

    // Datapath next-state: load on accept, advance in RUN, capture the digest at the end.
    always_comb begin
        wv_d     = wv_q;
        cnt_d    = cnt_q;
        digest_d = digest_q;
        for (int i = 0; i < 16; i++) begin
            win_d[i] = win_q[i];
        end
`ifdef SHA256_FEEDFWD_EN
        chain_d  = chain_q;
`endif
        case (fsm_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    wv_d  = bus.state_in;
                    cnt_d = '0;
                    for (int i = 0; i < 16; i++) begin
                        win_d[i] = bus.block_in[511-32*i -: 32];
                    end
`ifdef SHA256_FEEDFWD_EN
                    chain_d = bus.state_in;
`endif
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_RUN: begin
                wv_d  = rs_s[UNROLL];
                cnt_d = cnt_q + CNT_STEP;
                for (int i = 0; i < 16; i++) begin
                    win_d[i] = ext_s[UNROLL+i];
                end
                if (cnt_q == LAST_CNT) begin
`ifdef SHA256_FEEDFWD_EN
                    digest_d = add_words(chain_q, rs_s[UNROLL]);
`else
                    digest_d = rs_s[UNROLL];
`endif
                end else begin
                    digest_d = digest_q;
                end
            end
            ST_DONE: begin
                digest_d = digest_q;
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wv_q     <= '0;
            cnt_q    <= '0;
            digest_q <= '0;
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= 32'h0;
            end
`ifdef SHA256_FEEDFWD_EN
            chain_q  <= '0;
`endif
        end else begin
            wv_q     <= wv_d;
            cnt_q    <= cnt_d;
            digest_q <= digest_d;
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= win_d[i];
            end
`ifdef SHA256_FEEDFWD_EN
            chain_q  <= chain_d;
`endif
        end
    end

endmodule

// File: doc/sha256_compress_iter.md
Name: sha256_compress_iter

Overview:
- Parametrised iterative SHA-256 compression engine. Consumes one 512-bit message block plus a 256-bit chaining state and produces the 256-bit updated state.
- Executes UNROLL rounds per clock from an internal K-constant ROM. The message schedule is generated on the fly in a 16-word sliding window.
- Successor to the single-round combinational stage: adds schedule expansion, round sequencing, valid/ready handshakes and feed-forward.
- Sits between the block/midstate feeder and the nonce-check / second-hash logic.

Parameters:
- UNROLL, 1, rounds per clock; legal values 1, 2, 4, 8, 16; any other value must fail elaboration.
- CNT_W, 7, width of the round counter; must hold 64.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  block + state offered
- in_ready  out  1  engine idle, can accept
- block_in  in  512  message block; W0 = [511:480] … W15 = [31:0]
- state_in  in  256  chaining state; a = [255:224] … h = [31:0]
- out_valid  out  1  digest available
- out_ready  in  1  consumer accepts digest
- digest_out  out  256  result; same word order as state_in
- busy  out  1  high in RUN and DONE

Behaviour:
- Reset (async, rst_n low):
  - Outputs: in_ready=1 after release, out_valid=0, busy=0, digest_out=0.
  - Internals: FSM=IDLE, round counter=0, working registers and schedule window=0.
- FSM states IDLE, RUN, DONE:
  - IDLE: in_ready=1. When in_valid&in_ready on an edge:
    - Latch state_in into the working vars a..h and into the saved chaining register.
    - Latch block_in into the window W[0..15].
    - Clear counter; go to RUN.
  - RUN: in_ready=0. Each edge applies UNROLL consecutive rounds t=cnt … cnt+UNROLL-1.
    - Per round: T1=h+Σ1(e)+Ch(e,f,g)+K[t]+W[t]; T2=Σ0(a)+Maj(a,b,c).
    - Update: a←T1+T2, e←d+T1, remaining vars shift down.
    - W[t]: taken from the window for t<16. For t≥16, W[t]=σ1(W[t-2])+W[t-7]+σ0(W[t-15])+W[t-16].
    - Window advances UNROLL words per edge. cnt += UNROLL.
  - RUN → DONE: on the edge completing round 63, register digest_out. Each word is chaining_word + final_working_word, mod 2^32 per 32-bit word with no inter-word carry. out_valid rises on the same edge.
  - DONE: out_valid=1; digest_out held stable. On out_ready=1 edge: out_valid←0, FSM←IDLE. in_ready returns the cycle after; there is no combinational ready path.
- Latency: acceptance edge N → out_valid high after edge N+64/UNROLL. Throughput is one block per 64/UNROLL+2 cycles.
- Inputs in RUN/DONE:
  - in_valid while in_ready=0 is ignored; block_in/state_in are don't-care.
  - out_ready outside DONE is ignored.
- digest_out retains the last result after the handshake until the next completion.
- Arithmetic: all adds are 32-bit modulo 2^32. Σ/σ rotate amounts per FIPS 180-4.
- rst_n asserted mid-RUN or in DONE: immediate abort to the reset values above; no partial digest is emitted.

Optional Feature:
- Macro SHA256_FEEDFWD_EN.
- Defined: digest_out = chaining state + final working vars (standard compression output).
- Not defined: digest_out = raw final working vars a..h with no addition. The saved chaining register is removed. Used by the midstate pipeline, which performs the add externally.
- Latency and handshake are identical in both builds.

Test Plan:
- UNROLL=1, FEEDFWD on; "abc" padded block (0x61626380, zeros, len 0x18), IV 6a09e667…5be0cd19 → after 64 cycles out_valid=1, digest_out=ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- UNROLL=4; empty-message block (0x80000000, zeros, len 0) with IV → out_valid at cycle 16, digest e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- Backpressure: out_ready=0 for 10 cycles after out_valid → digest stable, in_ready=0. A new in_valid pulse is not accepted. out_ready=1 → in_ready=1 next cycle.
- Reset mid-RUN: rst_n low at round 30 → out_valid=0, busy=0, in_ready=1 after release. A fresh "abc" block then yields the correct digest.
- Back-to-back: in_valid held high with two blocks, out_ready tied 1 → two digests exactly 64/UNROLL+2 cycles apart; the second uses its own state_in.
- FEEDFWD off, "abc"/IV → digest_out equals expected digest minus IV word-wise (e.g. word0 = 0x506e3058).
